// File: rtl/fixdiv_pkg.sv
// Shared types and constants for the fixed-point divide responder.
package fixdiv_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ARMED,
    LD0,
    LD1,
    LD2,
    DIV,
    WR0,
    WR1,
    WR2,
    DONE
  } state_t;

  localparam int          DIV_CYCLES  = 24;
  localparam logic [23:0] DIV0_RESULT = 24'hFFFFFF;

  // operand byte offsets from the operand base address
  localparam int OFF_DVD_HI = 0;
  localparam int OFF_DVD_LO = 1;
  localparam int OFF_DVS    = 2;

  // result byte offsets from the result base address
  localparam int OFF_RES_HI  = 0;
  localparam int OFF_RES_MID = 1;
  localparam int OFF_RES_LO  = 2;

endpackage

// File: rtl/fixdiv_core.sv
// Serial restoring divider, 24-bit numerator by 8-bit divisor, one quotient
// bit per cycle MSB first. The load cycle already resolves the first bit, so
// busy stays high for the remaining DIV_CYCLES-1 steps and the quotient is
// final in the first cycle busy reads low.
module fixdiv_core
  import fixdiv_pkg::*;
(
  input  logic        Clk,
  input  logic        Reset,
  input  logic        load,
  input  logic [23:0] numerator,
  input  logic [7:0]  divisor,
  output logic        busy,
  output logic [23:0] quotient
);

  logic [8:0]  rem;
  logic [7:0]  dvs;
  logic [4:0]  count;

  logic [8:0]  src_rem;
  logic [23:0] src_num;
  logic [7:0]  src_dvs;
  logic [9:0]  trial;
  logic [9:0]  diff;
  logic        ge;
  logic [8:0]  rem_next;
  logic [23:0] quo_next;

  // One restoring step: shift in the next numerator bit, subtract if it fits.
  // Remainder stays below the divisor, so trial never exceeds 9 bits and the
  // borrow shows up cleanly in diff[9].
  always_comb begin
    src_rem  = load ? 9'd0 : rem;
    src_num  = load ? numerator : quotient;
    src_dvs  = load ? divisor : dvs;
    trial    = {src_rem, src_num[23]};
    diff     = trial - {2'b00, src_dvs};
    ge       = ~diff[9];
    rem_next = ge ? diff[8:0] : trial[8:0];
    quo_next = {src_num[22:0], ge};
  end

  // Remainder, quotient shift register and step counter.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      rem      <= '0;
      dvs      <= '0;
      quotient <= '0;
      count    <= '0;
    end else if (load) begin
      rem      <= rem_next;
      dvs      <= divisor;
      quotient <= quo_next;
      count    <= 5'(DIV_CYCLES - 1);
    end else if (count != 5'd0) begin
      rem      <= rem_next;
      quotient <= quo_next;
      count    <= count - 5'd1;
    end
  end

  assign busy = (count != 5'd0);

endmodule

// File: rtl/fixdiv_responder.sv
// Launch-handshake responder computing floor(dividend * 2^FRAC_BITS / divisor)
// from operands in data memory and writing the 24-bit result back.
//
// state | meaning
// IDLE  | waiting for Start to rise
// ARMED | Start high, launch on the first cycle it reads low
// LD0   | read dividend high byte
// LD1   | read dividend low byte
// LD2   | read divisor, start divider or take the divide-by-zero path
// DIV   | divider running
// WR0   | write result[23:16]
// WR1   | write result[15:8]
// WR2   | write result[7:0]
// DONE  | Ack high until Start is seen again
module fixdiv_responder
  import fixdiv_pkg::*;
#(
  parameter int AW        = 8,
  parameter int OPA_ADDR  = 0,
  parameter int RES_ADDR  = 4,
  parameter int FRAC_BITS = 8
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Start,
  output logic          Ack,
  output logic [AW-1:0] MemAddr,
  output logic          MemWrEn,
  output logic [7:0]    MemWrData,
  input  logic [7:0]    MemRdData
);

  localparam int QW = 16 + FRAC_BITS;

  localparam logic [AW-1:0] ADDR_DVD_HI = AW'(OPA_ADDR + OFF_DVD_HI);
  localparam logic [AW-1:0] ADDR_DVD_LO = AW'(OPA_ADDR + OFF_DVD_LO);
  localparam logic [AW-1:0] ADDR_DVS    = AW'(OPA_ADDR + OFF_DVS);
  localparam logic [AW-1:0] ADDR_RES_HI = AW'(RES_ADDR + OFF_RES_HI);
  localparam logic [AW-1:0] ADDR_RES_MD = AW'(RES_ADDR + OFF_RES_MID);
  localparam logic [AW-1:0] ADDR_RES_LO = AW'(RES_ADDR + OFF_RES_LO);

  state_t          state;
  state_t          state_next;
  logic [15:0]     dividend;
  logic            div0;
  logic [AW-1:0]   addr_hold;
  logic [AW-1:0]   addr_c;
  logic            ack_r;
  logic            ack_d;
  logic            core_load;
  logic            core_busy;
  logic [QW-1:0]   numerator;
  logic [QW-1:0]   core_q;
  logic [QW-1:0]   result;

  assign numerator = {dividend, {FRAC_BITS{1'b0}}};
  assign result    = div0 ? QW'(DIV0_RESULT) : core_q;

  fixdiv_core u_core (
    .Clk       (Clk),
    .Reset     (Reset),
    .load      (core_load),
    .numerator (numerator),
    .divisor   (MemRdData),
    .busy      (core_busy),
    .quotient  (core_q)
  );

  // Next-state decode plus memory-bus and Ack drive; address holds outside LD/WR.
  always_comb begin
    state_next = state;
    core_load  = 1'b0;
    addr_c     = addr_hold;
    MemWrEn    = 1'b0;
    MemWrData  = 8'h00;
    ack_d      = 1'b0;
    case (state)
      IDLE:  if (Start) state_next = ARMED;
      ARMED: if (!Start) state_next = LD0;
      LD0: begin
        addr_c     = ADDR_DVD_HI;
        state_next = LD1;
      end
      LD1: begin
        addr_c     = ADDR_DVD_LO;
        state_next = LD2;
      end
      LD2: begin
        addr_c = ADDR_DVS;
        if (MemRdData == 8'h00) begin
          state_next = WR0;
        end else begin
          core_load  = 1'b1;
          state_next = DIV;
        end
      end
      DIV:   if (!core_busy) state_next = WR0;
      WR0: begin
        addr_c     = ADDR_RES_HI;
        MemWrEn    = 1'b1;
        MemWrData  = result[23:16];
        state_next = WR1;
      end
      WR1: begin
        addr_c     = ADDR_RES_MD;
        MemWrEn    = 1'b1;
        MemWrData  = result[15:8];
        state_next = WR2;
      end
      WR2: begin
        addr_c     = ADDR_RES_LO;
        MemWrEn    = 1'b1;
        MemWrData  = result[7:0];
        state_next = DONE;
      end
      DONE: begin
        if (Start) begin
          state_next = ARMED;
        end else begin
          ack_d = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign MemAddr = addr_c;
  assign Ack     = ack_r;

  // State, operand capture, held address and registered Ack.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= IDLE;
      dividend  <= '0;
      div0      <= 1'b0;
      addr_hold <= '0;
      ack_r     <= 1'b0;
    end else begin
      state     <= state_next;
      addr_hold <= addr_c;
      ack_r     <= ack_d;
      if (state == LD0) dividend[15:8] <= MemRdData;
      if (state == LD1) dividend[7:0]  <= MemRdData;
      if (state == LD2) div0           <= (MemRdData == 8'h00);
    end
  end

endmodule

// File: tb/tb_fixdiv_responder.sv
// Scoreboard bench for fixdiv_responder: the driver pushes the expected
// result and latency for each launch, the monitor pops and compares on each
// rising Ack.
module tb_fixdiv_responder;
  import fixdiv_pkg::*;

  logic       Clk;
  logic       Reset;
  logic       Start;
  logic       Ack;
  logic [7:0] MemAddr;
  logic       MemWrEn;
  logic [7:0] MemWrData;
  logic [7:0] MemRdData;

  logic [7:0] opmem  [0:3];
  logic [7:0] resmem [0:2];

  typedef struct {
    logic [23:0] q;
    int          lat;
    bit          div;
  } exp_t;

  exp_t sb[$];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int launch_cyc = 0;
  int done_cnt = 0;
  int wr_cnt   = 0;
  bit div_seen = 0;
  logic ack_prev = 1'b0;

  fixdiv_responder dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Start     (Start),
    .Ack       (Ack),
    .MemAddr   (MemAddr),
    .MemWrEn   (MemWrEn),
    .MemWrData (MemWrData),
    .MemRdData (MemRdData)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  assign MemRdData = (MemAddr < 8'd3) ? opmem[MemAddr[1:0]] : 8'h00;

  always @(posedge Clk) begin
    cyc <= cyc + 1;
    if (MemWrEn && MemAddr[7:2] == 6'd1 && MemAddr[1:0] != 2'd3)
      resmem[MemAddr[1:0]] <= MemWrData;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // monitor: per-run write count, DIV visit, and result check on Ack rise
  always @(negedge Clk) begin
    exp_t e;
    if (dut.state == ARMED) begin
      wr_cnt   = 0;
      div_seen = 0;
    end
    if (MemWrEn) wr_cnt++;
    if (dut.state == DIV) div_seen = 1;
    if (Ack && !ack_prev) begin
      if (sb.size() == 0) begin
        check("unexpected_ack", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("result", {8'h00, resmem[0], resmem[1], resmem[2]}, {8'h00, e.q});
        check("latency", 32'(cyc - launch_cyc), 32'(e.lat));
        check("wr_pulses", 32'(wr_cnt), 32'd3);
        check("div_entered", {31'd0, div_seen}, {31'd0, e.div});
      end
      done_cnt++;
    end
    ack_prev = Ack;
  end

  task automatic set_ops(input logic [15:0] a, input logic [7:0] b);
    opmem[0] = a[15:8];
    opmem[1] = a[7:0];
    opmem[2] = b;
  endtask

  // starts at a negedge: Start high for two sampling edges, then low
  task automatic launch(output logic had_ack);
    had_ack = Ack;
    Start = 1'b1;
    @(posedge Clk);
    #1;
    if (had_ack) check("ack_drop", {31'd0, Ack}, 32'd0);
    @(posedge Clk);
    @(negedge Clk);
    Start = 1'b0;
    launch_cyc = cyc + 1;
  endtask

  task automatic run(input logic [15:0] a, input logic [7:0] b);
    exp_t e;
    int   start_done;
    logic had_ack;
    int unsigned num;
    set_ops(a, b);
    num = {8'h00, a, 8'h00};
    e.q   = (b == 8'h00) ? 24'hFFFFFF : 24'(num / 32'(b));
    e.lat = (b == 8'h00) ? 7 : 31;
    e.div = (b != 8'h00);
    sb.push_back(e);
    start_done = done_cnt;
    launch(had_ack);
    for (int i = 0; i < 60 && done_cnt == start_done; i++) @(posedge Clk);
    if (done_cnt == start_done) begin
      failures++;
      $display("FAIL ack_timeout: no Ack for %0h/%0h", a, b);
      void'(sb.pop_front());
    end
    @(negedge Clk);
  endtask

  initial begin
    logic had_ack;
    logic [15:0] ra;
    logic [7:0]  rb;
    Reset = 1'b1;
    Start = 1'b0;
    for (int i = 0; i < 4; i++) opmem[i] = 8'h00;
    for (int i = 0; i < 3; i++) resmem[i] = 8'h00;
    repeat (3) @(posedge Clk);
    #1;
    check("rst_ack", {31'd0, Ack}, 32'd0);
    check("rst_wren", {31'd0, MemWrEn}, 32'd0);
    check("rst_addr", {24'd0, MemAddr}, 32'd0);
    check("rst_wdata", {24'd0, MemWrData}, 32'd0);
    check("rst_state", 32'(dut.state), 32'(IDLE));
    @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);

    run(16'h3200, 8'h19);
    run(16'h0181, 8'h06);
    run(16'h1234, 8'h00);
    run(16'hFFFF, 8'h01);
    run(16'h0001, 8'hFF);
    run(16'h0000, 8'h07);
    run(16'hFFFF, 8'hFF);

    // reset in the middle of a divide
    set_ops(16'h3200, 8'h19);
    launch(had_ack);
    repeat (13) @(posedge Clk);
    @(negedge Clk);
    check("pre_rst_state", 32'(dut.state), 32'(DIV));
    Reset = 1'b1;
    @(posedge Clk);
    #1;
    check("mid_rst_ack", {31'd0, Ack}, 32'd0);
    check("mid_rst_wren", {31'd0, MemWrEn}, 32'd0);
    check("mid_rst_state", 32'(dut.state), 32'(IDLE));
    check("mid_rst_mem", {8'h00, resmem[0], resmem[1], resmem[2]}, 32'h00010100);
    @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    run(16'h3200, 8'h19);

    for (int n = 0; n < 500; n++) begin
      ra = 16'($urandom_range(0, 65535));
      rb = (n % 25 == 0) ? 8'h00 : 8'($urandom_range(0, 255));
      run(ra, rb);
    end

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
